ysyx_25040129_bus_arbiter: RTL and testbench
============================================

Name:
ysyx_25040129_bus_arbiter

Overview:
- Shares the single AXI-style memory port, which leads into the MMU request side, between two masters: the instruction fetch unit (IFU, read-only, burst-capable) and the load/store unit (LSU, single-beat read and write).
- Grants one transaction at a time and holds the grant until the transaction completes: last R beat or B handshake.
- Routes each response back to the granted master only.
- Uses round-robin fairness between IFU and LSU.

Parameters:
- ADDR_W, 32, address width on all channels.
- DATA_W, 32, data width; wstrb width is DATA_W/8.

Ports:
Ports are bundled per AXI channel.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low (asserted at 0).
- ifu_araddr/ifu_arlen  in  32/8  IFU read address and burst length; ifu_arvalid in 1; ifu_arready out 1.
- ifu_rdata/ifu_rresp  out  32/2  IFU read data; ifu_rvalid out 1; ifu_rlast out 1; ifu_rready in 1.
- lsu_araddr/lsu_arsize  in  32/3  LSU read address and size; lsu_arvalid in 1; lsu_arready out 1.
- lsu_rdata/lsu_rresp  out  32/2  LSU read data; lsu_rvalid out 1; lsu_rready in 1.
- lsu_awaddr  in  32; lsu_awvalid in 1; lsu_awready out 1.
- lsu_wdata/lsu_wstrb  in  32/4; lsu_wvalid in 1; lsu_wready out 1.
- lsu_bresp  out  2; lsu_bvalid out 1; lsu_bready in 1.
- out_araddr/out_arsize/out_arlen/out_arburst  out  32/3/8/2; out_arvalid out 1; out_arready in 1.
- out_rdata/out_rresp  in  32/2; out_rvalid in 1; out_rlast in 1; out_rready out 1.
- out_awaddr out 32; out_awvalid out 1; out_awready in 1.
- out_wdata/out_wstrb out 32/4; out_wvalid out 1; out_wready in 1.
- out_bresp in 2; out_bvalid in 1; out_bready out 1.
- arb_err  out  1  sticky flag for an R-beat count mismatch.

Behaviour:
- States: IDLE, IFU_AR, IFU_R, LSU_AR, LSU_R, LSU_WR, LSU_B.
- Reset (rst=0, async): state=IDLE, last_grant=LSU, aw_done=w_done=0, beat_cnt=0, arb_err=0. Every out_*valid, out_rready, out_bready and every upstream ready/valid is 0 immediately, without waiting for a clock edge.
- Request definitions:
  - IFU request = ifu_arvalid.
  - LSU write request = lsu_awvalid && lsu_wvalid.
  - LSU read request = lsu_arvalid.
  - Within the LSU, a write wins over a read.
- IDLE arbitration: registered, so it adds 1 cycle of latency from request to out_*valid.
  - If only one master requests, it is granted.
  - If both request, the master that is not last_grant wins.
  - last_grant updates on entry to any *_AR or LSU_WR state.
  - No request: stay in IDLE.
- IFU_AR:
  - Drives out_araddr=ifu_araddr, out_arlen=ifu_arlen, out_arsize=3'b010, out_arburst=2'b01, out_arvalid=1.
  - ifu_arready=out_arready.
  - On out_arready: load beat_cnt=ifu_arlen, go to IFU_R.
- IFU_R:
  - ifu_r* = out_r*; out_rready=ifu_rready.
  - Each beat (out_rvalid && out_rready) decrements beat_cnt.
  - A beat with out_rlast=1 goes to IDLE. If beat_cnt!=0 at that beat, set arb_err.
  - A beat with beat_cnt==0 and out_rlast=0 sets arb_err; stay in IFU_R until rlast arrives.
- LSU_AR:
  - Drives out_araddr=lsu_araddr, out_arsize=lsu_arsize, out_arlen=0, out_arburst=2'b01.
  - Handshake as in IFU_AR, then go to LSU_R.
- LSU_R: same as IFU_R with lsu_r*. lsu_rlast is not exported.
- LSU_WR:
  - out_awvalid = !aw_done; out_wvalid = !w_done.
  - Address, data and strobe pass through; lsu_awready/lsu_wready mirror out_awready/out_wready while not yet done.
  - Each handshake sets its done flag.
  - When both are done, including simultaneously in the same cycle: clear both flags and go to LSU_B.
- LSU_B:
  - lsu_bvalid=out_bvalid; out_bready=lsu_bready; lsu_bresp=out_bresp.
  - On handshake: go to IDLE.
- Routing: a non-granted master always sees ready=0 and valid=0. out_rdata/out_rresp/out_bresp may fan out, but valids are gated.
- Bubble: exactly one IDLE cycle between consecutive transactions.
- rresp/bresp pass through unmodified; errors are not retried.
- arb_err clears only on reset.

Test Plan:
- IFU alone, ifu_araddr=0x80000000, arlen=3, slave returns 4 beats with rlast on beat 4 -> out_arvalid rises 1 cycle after ifu_arvalid; 4 beats reach the IFU only; state returns to IDLE; arb_err=0.
- IFU and LSU read requests in the same cycle after reset -> IFU granted first; LSU granted one IDLE cycle after IFU's last beat; then swap the order and check round-robin.
- LSU write, awaddr=0x80001000, wdata=0xdeadbeef, wstrb=4'hf; out_wready 2 cycles before out_awready -> the W handshake finishes first; LSU_B entered only after AW; bresp=0 delivered; the IFU sees no ready.
- LSU write and read both valid -> the write completes through B before the read is issued.
- IFU burst arlen=1 where the slave asserts rlast on beat 1 -> arb_err=1 and stays 1; the next transactions still proceed.
- rst driven low mid IFU_R with out_rvalid high -> all valids and readys drop to 0 in the same cycle; after release, state is IDLE.

Source files
------------

// File: rtl/ysyx_25040129_bus_arbiter_if.sv
// AXI-style bus bundle (AR/R/AW/W/B) shared by the IFU, LSU and memory-side ports.
// The master modport issues requests; the slave modport answers them.
interface ysyx_25040129_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rlast;
    logic                rready;
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output araddr, arlen, arsize, arburst, arvalid, rready,
               awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, rlast, awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arlen, arsize, arburst, arvalid, rready,
               awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, rlast, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/ysyx_25040129_bus_arbiter.sv
// Round-robin arbiter sharing one AXI-style memory port between the IFU (burst reads)
// and the LSU (single-beat reads/writes); one transaction in flight at a time.
module ysyx_25040129_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    ysyx_25040129_bus_arbiter_if.slave        ifu,
    ysyx_25040129_bus_arbiter_if.slave        lsu,
    ysyx_25040129_bus_arbiter_if.master       out,
    output logic                              arb_err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        IFU_AR = 3'd1,
        IFU_R  = 3'd2,
        LSU_AR = 3'd3,
        LSU_R  = 3'd4,
        LSU_WR = 3'd5,
        LSU_B  = 3'd6
    } state_e;

    typedef enum logic {
        GNT_IFU = 1'b0,
        GNT_LSU = 1'b1
    } grant_e;

    state_e      state_q,      state_d;
    grant_e      last_grant_q, last_grant_d;
    logic        aw_done_q,    aw_done_d;
    logic        w_done_q,     w_done_d;
    logic [7:0]  beat_cnt_q,   beat_cnt_d;
    logic        arb_err_q,    arb_err_d;

    logic        ifu_req_s;
    logic        lsu_wr_req_s;
    logic        lsu_req_s;
    logic        aw_next_s;
    logic        w_next_s;
    logic        unused_s;

    assign ifu_req_s    = ifu.arvalid;
    assign lsu_wr_req_s = lsu.awvalid && lsu.wvalid;
    assign lsu_req_s    = lsu_wr_req_s || lsu.arvalid;
    assign arb_err      = arb_err_q;

    // Master-side fields this arbiter never consumes (IFU has no write path).
    assign unused_s = ^{ifu.arsize, ifu.arburst, ifu.awaddr, ifu.awvalid, ifu.wdata,
                        ifu.wstrb, ifu.wvalid, ifu.bready, lsu.arlen, lsu.arburst};

    // Next-state, grant history, write-progress flags and beat accounting.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        beat_cnt_d   = beat_cnt_q;
        arb_err_d    = arb_err_q;
        aw_next_s    = aw_done_q || (out.awvalid && out.awready);
        w_next_s     = w_done_q  || (out.wvalid  && out.wready);
        case (state_q)
            IDLE: begin
                // On contention the master that was not served last wins.
                if (ifu_req_s && (!lsu_req_s || (last_grant_q == GNT_LSU))) begin
                    state_d      = IFU_AR;
                    last_grant_d = GNT_IFU;
                end else if (lsu_wr_req_s) begin
                    state_d      = LSU_WR;
                    last_grant_d = GNT_LSU;
                end else if (lsu.arvalid) begin
                    state_d      = LSU_AR;
                    last_grant_d = GNT_LSU;
                end else begin
                    state_d      = IDLE;
                end
            end
            IFU_AR: begin
                if (out.arready) begin
                    beat_cnt_d = ifu.arlen;
                    state_d    = IFU_R;
                end else begin
                    state_d    = IFU_AR;
                end
            end
            LSU_AR: begin
                if (out.arready) begin
                    beat_cnt_d = 8'd0;
                    state_d    = LSU_R;
                end else begin
                    state_d    = LSU_AR;
                end
            end
            IFU_R, LSU_R: begin
                if (out.rvalid && out.rready) begin
                    if (out.rlast) begin
                        state_d = IDLE;
                        if (beat_cnt_q != 8'd0) begin
                            arb_err_d = 1'b1;
                        end else begin
                            arb_err_d = arb_err_q;
                        end
                    end else if (beat_cnt_q == 8'd0) begin
                        arb_err_d = 1'b1;
                    end else begin
                        beat_cnt_d = beat_cnt_q - 8'd1;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            LSU_WR: begin
                if (aw_next_s && w_next_s) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = LSU_B;
                end else begin
                    aw_done_d = aw_next_s;
                    w_done_d  = w_next_s;
                end
            end
            LSU_B: begin
                if (out.bvalid && out.bready) begin
                    state_d = IDLE;
                end else begin
                    state_d = LSU_B;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset forces IDLE so every gated valid/ready drops at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_grant_q <= GNT_LSU;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            beat_cnt_q   <= 8'd0;
            arb_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            beat_cnt_q   <= beat_cnt_d;
            arb_err_q    <= arb_err_d;
        end
    end

    // Channel routing: data fans out freely, handshakes are gated by the registered state.
    always_comb begin
        out.araddr  = {ADDR_W{1'b0}};
        out.arlen   = 8'd0;
        out.arsize  = 3'b000;
        out.arburst = 2'b00;
        out.arvalid = 1'b0;
        out.rready  = 1'b0;
        out.awaddr  = lsu.awaddr;
        out.awvalid = 1'b0;
        out.wdata   = lsu.wdata;
        out.wstrb   = lsu.wstrb;
        out.wvalid  = 1'b0;
        out.bready  = 1'b0;

        ifu.arready = 1'b0;
        ifu.rdata   = out.rdata;
        ifu.rresp   = out.rresp;
        ifu.rvalid  = 1'b0;
        ifu.rlast   = 1'b0;
        ifu.awready = 1'b0;
        ifu.wready  = 1'b0;
        ifu.bresp   = 2'b00;
        ifu.bvalid  = 1'b0;

        lsu.arready = 1'b0;
        lsu.rdata   = out.rdata;
        lsu.rresp   = out.rresp;
        lsu.rvalid  = 1'b0;
        lsu.rlast   = 1'b0;
        lsu.awready = 1'b0;
        lsu.wready  = 1'b0;
        lsu.bresp   = out.bresp;
        lsu.bvalid  = 1'b0;

        case (state_q)
            IFU_AR: begin
                out.araddr  = ifu.araddr;
                out.arlen   = ifu.arlen;
                out.arsize  = 3'b010;
                out.arburst = 2'b01;
                out.arvalid = 1'b1;
                ifu.arready = out.arready;
            end
            LSU_AR: begin
                out.araddr  = lsu.araddr;
                out.arlen   = 8'd0;
                out.arsize  = lsu.arsize;
                out.arburst = 2'b01;
                out.arvalid = 1'b1;
                lsu.arready = out.arready;
            end
            IFU_R: begin
                out.rready  = ifu.rready;
                ifu.rvalid  = out.rvalid;
                ifu.rlast   = out.rlast;
            end
            LSU_R: begin
                out.rready  = lsu.rready;
                lsu.rvalid  = out.rvalid;
            end
            LSU_WR: begin
                out.awvalid = !aw_done_q;
                out.wvalid  = !w_done_q;
                lsu.awready = out.awready && !aw_done_q;
                lsu.wready  = out.wready  && !w_done_q;
            end
            LSU_B: begin
                out.bready  = lsu.bready;
                lsu.bvalid  = out.bvalid;
            end
            default: begin
                out.arvalid = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ysyx_25040129_bus_arbiter.sv
// Directed bench for the IFU/LSU bus arbiter: grant order, routing, write ordering,
// beat-count error flag and asynchronous reset.
module tb_ysyx_25040129_bus_arbiter;

    logic clk;
    logic rst;
    logic arb_err;
    int   tests;
    int   fails;

    ysyx_25040129_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ib ();
    ysyx_25040129_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) lb ();
    ysyx_25040129_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mb ();

    ysyx_25040129_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .ifu     (ib),
        .lsu     (lb),
        .out     (mb),
        .arb_err (arb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ib.araddr = 32'd0; ib.arlen = 8'd0; ib.arsize = 3'd0; ib.arburst = 2'd0;
        ib.arvalid = 1'b0; ib.rready = 1'b1; ib.awaddr = 32'd0; ib.awvalid = 1'b0;
        ib.wdata = 32'd0; ib.wstrb = 4'd0; ib.wvalid = 1'b0; ib.bready = 1'b0;
        lb.araddr = 32'd0; lb.arlen = 8'd0; lb.arsize = 3'd0; lb.arburst = 2'd0;
        lb.arvalid = 1'b0; lb.rready = 1'b1; lb.awaddr = 32'd0; lb.awvalid = 1'b0;
        lb.wdata = 32'd0; lb.wstrb = 4'd0; lb.wvalid = 1'b0; lb.bready = 1'b1;
        mb.arready = 1'b0; mb.rdata = 32'd0; mb.rresp = 2'd0; mb.rvalid = 1'b0;
        mb.rlast = 1'b0; mb.awready = 1'b0; mb.wready = 1'b0; mb.bresp = 2'd0;
        mb.bvalid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_inputs();
        tick();
        tick();
        rst = 1'b1;
    endtask

    // One R beat from the slave; checks that it reaches only the expected master.
    task automatic r_beat(input string tag, input logic [31:0] d, input logic last,
                          input logic to_ifu);
        mb.rvalid = 1'b1;
        mb.rdata  = d;
        mb.rlast  = last;
        #1;
        chk({tag, "_ifu_rvalid"}, 64'(ib.rvalid), 64'(to_ifu));
        chk({tag, "_lsu_rvalid"}, 64'(lb.rvalid), 64'(!to_ifu));
        chk({tag, "_rdata"}, 64'(to_ifu ? ib.rdata : lb.rdata), 64'(d));
        tick();
        mb.rvalid = 1'b0;
        mb.rlast  = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b0;
        clear_inputs();
        #1;
        chk("rst_out_arvalid", 64'(mb.arvalid), 64'd0);
        chk("rst_out_rready", 64'(mb.rready), 64'd0);
        chk("rst_arb_err", 64'(arb_err), 64'd0);
        tick();
        rst = 1'b1;

        // IFU alone, 4-beat burst.
        ib.arvalid = 1'b1; ib.araddr = 32'h8000_0000; ib.arlen = 8'd3;
        #1;
        chk("t1_no_arvalid_yet", 64'(mb.arvalid), 64'd0);
        tick();
        chk("t1_arvalid", 64'(mb.arvalid), 64'd1);
        chk("t1_araddr", 64'(mb.araddr), 64'h8000_0000);
        chk("t1_arlen", 64'(mb.arlen), 64'd3);
        chk("t1_arsize", 64'(mb.arsize), 64'd2);
        chk("t1_arburst", 64'(mb.arburst), 64'd1);
        chk("t1_arready_low", 64'(ib.arready), 64'd0);
        mb.arready = 1'b1;
        #1;
        chk("t1_arready_pass", 64'(ib.arready), 64'd1);
        tick();
        ib.arvalid = 1'b0; mb.arready = 1'b0;
        #1;
        chk("t1_r_arvalid_low", 64'(mb.arvalid), 64'd0);
        chk("t1_rready", 64'(mb.rready), 64'd1);
        for (int b = 0; b < 4; b++) begin
            r_beat("t1_beat", 32'h1000 + 32'(b), (b == 3), 1'b1);
        end
        chk("t1_idle_rready", 64'(mb.rready), 64'd0);
        chk("t1_arb_err", 64'(arb_err), 64'd0);

        // Simultaneous reads after reset: IFU first, one bubble, then LSU.
        do_reset();
        ib.arvalid = 1'b1; ib.araddr = 32'h8000_0100; ib.arlen = 8'd0;
        lb.arvalid = 1'b1; lb.araddr = 32'h8000_2000; lb.arsize = 3'd2;
        mb.arready = 1'b1;
        tick();
        chk("t2_first_addr", 64'(mb.araddr), 64'h8000_0100);
        chk("t2_lsu_arready_blocked", 64'(lb.arready), 64'd0);
        tick();
        ib.arvalid = 1'b0;
        r_beat("t2_ifu", 32'hAAAA_0001, 1'b1, 1'b1);
        chk("t2_bubble", 64'(mb.arvalid), 64'd0);
        tick();
        chk("t2_lsu_addr", 64'(mb.araddr), 64'h8000_2000);
        chk("t2_lsu_arlen", 64'(mb.arlen), 64'd0);
        chk("t2_lsu_arready", 64'(lb.arready), 64'd1);
        chk("t2_ifu_arready", 64'(ib.arready), 64'd0);
        tick();
        lb.arvalid = 1'b0;
        r_beat("t2_lsu", 32'hBBBB_0002, 1'b1, 1'b0);

        // Swapped history: IFU served last, so LSU wins the next contention.
        ib.arvalid = 1'b1;
        tick();
        tick();
        ib.arvalid = 1'b0;
        r_beat("t2b_ifu", 32'hCCCC_0003, 1'b1, 1'b1);
        ib.arvalid = 1'b1; lb.arvalid = 1'b1;
        tick();
        chk("t2b_lsu_wins", 64'(mb.araddr), 64'h8000_2000);
        chk("t2b_ifu_blocked", 64'(ib.arready), 64'd0);
        tick();
        lb.arvalid = 1'b0;
        r_beat("t2b_lsu", 32'hDDDD_0004, 1'b1, 1'b0);
        tick();
        chk("t2b_ifu_next", 64'(mb.araddr), 64'h8000_0100);
        tick();
        ib.arvalid = 1'b0;
        r_beat("t2b_ifu2", 32'hEEEE_0005, 1'b1, 1'b1);

        // LSU write with W accepted two cycles before AW.
        mb.arready = 1'b1;
        lb.awvalid = 1'b1; lb.awaddr = 32'h8000_1000;
        lb.wvalid = 1'b1; lb.wdata = 32'hdead_beef; lb.wstrb = 4'hf;
        tick();
        chk("t3_awvalid", 64'(mb.awvalid), 64'd1);
        chk("t3_wvalid", 64'(mb.wvalid), 64'd1);
        chk("t3_awaddr", 64'(mb.awaddr), 64'h8000_1000);
        chk("t3_wdata", 64'(mb.wdata), 64'hdead_beef);
        chk("t3_wstrb", 64'(mb.wstrb), 64'hf);
        mb.wready = 1'b1;
        #1;
        chk("t3_lsu_wready", 64'(lb.wready), 64'd1);
        chk("t3_lsu_awready", 64'(lb.awready), 64'd0);
        tick();
        lb.wvalid = 1'b0; mb.wready = 1'b0;
        #1;
        chk("t3_w_done", 64'(mb.wvalid), 64'd0);
        chk("t3_aw_pending", 64'(mb.awvalid), 64'd1);
        tick();
        chk("t3_no_b_yet", 64'(mb.bready), 64'd0);
        mb.awready = 1'b1;
        #1;
        chk("t3_lsu_awready_pass", 64'(lb.awready), 64'd1);
        tick();
        lb.awvalid = 1'b0; mb.awready = 1'b0;
        #1;
        chk("t3_b_awvalid_low", 64'(mb.awvalid), 64'd0);
        chk("t3_bready", 64'(mb.bready), 64'd1);
        mb.bvalid = 1'b1; mb.bresp = 2'b00;
        #1;
        chk("t3_bvalid", 64'(lb.bvalid), 64'd1);
        chk("t3_bresp", 64'(lb.bresp), 64'd0);
        chk("t3_ifu_no_ready", 64'(ib.arready), 64'd0);
        tick();
        mb.bvalid = 1'b0;
        #1;
        chk("t3_idle_bready", 64'(mb.bready), 64'd0);

        // Write and read together: write runs through B before the read is issued.
        lb.awvalid = 1'b1; lb.wvalid = 1'b1; lb.arvalid = 1'b1; lb.araddr = 32'h8000_3000;
        mb.awready = 1'b1; mb.wready = 1'b1;
        tick();
        chk("t4_wr_first", 64'(mb.awvalid), 64'd1);
        chk("t4_no_ar", 64'(mb.arvalid), 64'd0);
        tick();
        lb.awvalid = 1'b0; lb.wvalid = 1'b0;
        mb.bvalid = 1'b1; mb.bresp = 2'b10;
        #1;
        chk("t4_in_b_no_aw", 64'(mb.awvalid), 64'd0);
        chk("t4_in_b_no_ar", 64'(mb.arvalid), 64'd0);
        chk("t4_bresp", 64'(lb.bresp), 64'd2);
        chk("t4_bvalid", 64'(lb.bvalid), 64'd1);
        tick();
        mb.bvalid = 1'b0;
        #1;
        chk("t4_bubble", 64'(mb.arvalid), 64'd0);
        tick();
        chk("t4_read_issued", 64'(mb.arvalid), 64'd1);
        chk("t4_read_addr", 64'(mb.araddr), 64'h8000_3000);
        tick();
        lb.arvalid = 1'b0;
        r_beat("t4_lsu", 32'h1234_5678, 1'b1, 1'b0);

        // Early rlast: arlen=1 but slave ends after one beat.
        ib.arvalid = 1'b1; ib.arlen = 8'd1;
        tick();
        tick();
        ib.arvalid = 1'b0;
        chk("t5_err_before", 64'(arb_err), 64'd0);
        r_beat("t5_short", 32'h5555_0000, 1'b1, 1'b1);
        chk("t5_err_set", 64'(arb_err), 64'd1);
        ib.arvalid = 1'b1; ib.arlen = 8'd0;
        tick();
        chk("t5_next_grant", 64'(mb.arvalid), 64'd1);
        tick();
        ib.arvalid = 1'b0;
        r_beat("t5_next", 32'h5555_0001, 1'b1, 1'b1);
        chk("t5_err_sticky", 64'(arb_err), 64'd1);

        // Asynchronous reset in the middle of an IFU burst.
        ib.arvalid = 1'b1; ib.arlen = 8'd3;
        tick();
        tick();
        ib.arvalid = 1'b0;
        mb.rvalid = 1'b1; mb.rdata = 32'h6666_0000;
        #1;
        chk("t6_pre_rvalid", 64'(ib.rvalid), 64'd1);
        rst = 1'b0;
        #1;
        chk("t6_rvalid_drop", 64'(ib.rvalid), 64'd0);
        chk("t6_rready_drop", 64'(mb.rready), 64'd0);
        chk("t6_arvalid_drop", 64'(mb.arvalid), 64'd0);
        chk("t6_arready_drop", 64'(ib.arready), 64'd0);
        chk("t6_err_clear", 64'(arb_err), 64'd0);
        mb.rvalid = 1'b0;
        tick();
        rst = 1'b1;
        ib.arvalid = 1'b1; ib.arlen = 8'd0;
        #1;
        chk("t6_idle_latency", 64'(mb.arvalid), 64'd0);
        tick();
        chk("t6_idle_grant", 64'(mb.arvalid), 64'd1);
        tick();
        ib.arvalid = 1'b0;

        // Extra beat without rlast when the count is exhausted.
        r_beat("t7_overrun", 32'h7777_0000, 1'b0, 1'b1);
        chk("t7_err_set", 64'(arb_err), 64'd1);
        r_beat("t7_last", 32'h7777_0001, 1'b1, 1'b1);
        chk("t7_idle", 64'(mb.rready), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
